branch_pred_unit: RTL

BRANCH_PRED_UNIT -- requirements
Module: branch_pred_unit

---
 rtl/branch_pred_unit.sv | 114 +++++++++++
 1 files changed

// File: rtl/branch_pred_unit.sv
// Branch resolution and prediction unit: condition evaluation on live or stored
// flags, a table of 2-bit saturating counters, a mispredict flush pulse and a statistics counter.
module branch_pred_unit #(
  parameter int DW    = 16,
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flag_we,
  input  logic [DW-1:0]    wb_val,
  input  logic             c_out,
  input  logic [IDX_W-1:0] pred_idx,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic             jmp,
  input  logic             brc,
  input  logic [4:0]       cond,
  input  logic [IDX_W-1:0] res_idx,
  input  logic             res_pred,
  output logic             jmp_true_q,
  output logic             mispredict_q,
  output logic [3:0]       flags_q,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]       ctr_r [DEPTH];
  logic [3:0]       flags_r;
  logic             jmp_true_r;
  logic             mispredict_r;
  logic [CNT_W-1:0] cnt_r;

  logic [7:0] live_t_s;
  logic [7:0] stored_t_s;
  logic       cond_s;
  logic       taken_s;
  logic       mispred_s;
  logic       upd_s;

  // Tests ordered zero, nzero, cout, ncout, odd, even, msb, nmsb; flags_r is {M,O,C,Z}.
  assign live_t_s   = {~wb_val[DW-1], wb_val[DW-1], ~wb_val[0], wb_val[0],
                       ~c_out, c_out, ~(wb_val == {DW{1'b0}}), (wb_val == {DW{1'b0}})};
  assign stored_t_s = {~flags_r[3], flags_r[3], ~flags_r[2], flags_r[2],
                       ~flags_r[1], flags_r[1], ~flags_r[0], flags_r[0]};

  // Condition select and resolved-taken decision.
  always_comb begin
    cond_s = 1'b0;
    case (cond[4:3])
      2'b00:   cond_s = live_t_s[cond[2:0]];
      2'b01:   cond_s = stored_t_s[cond[2:0]];
      default: cond_s = 1'b0;
    endcase
    if (!jmp) begin
      taken_s = 1'b0;
    end else if (!brc) begin
      taken_s = 1'b1;
    end else begin
      taken_s = cond_s;
    end
  end

  assign mispred_s  = res_valid & jmp & (taken_s != res_pred);
  assign upd_s      = res_valid & jmp & brc;
  // Table read sees registered state only, so a same-cycle update is not bypassed.
  assign pred_taken = ctr_r[pred_idx][1];

  // Predictor counter table.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_r[i] <= 2'b01;
      end
    end else if (upd_s) begin
      if (taken_s) begin
        if (ctr_r[res_idx] != 2'b11) begin
          ctr_r[res_idx] <= ctr_r[res_idx] + 2'b01;
        end
      end else begin
        if (ctr_r[res_idx] != 2'b00) begin
          ctr_r[res_idx] <= ctr_r[res_idx] - 2'b01;
        end
      end
    end
  end

  // Flags, resolution outputs and mispredict statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_r      <= 4'b0000;
      jmp_true_r   <= 1'b0;
      mispredict_r <= 1'b0;
      cnt_r        <= {CNT_W{1'b0}};
    end else begin
      if (flag_we) begin
        flags_r <= {wb_val[DW-1], wb_val[0], c_out, (wb_val == {DW{1'b0}})};
      end
      jmp_true_r   <= res_valid & taken_s;
      mispredict_r <= mispred_s;
      // Count each pulse as it is registered so the count moves with mispredict_q.
      if (mispred_s && !(&cnt_r)) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign flags_q      = flags_r;
  assign jmp_true_q   = jmp_true_r;
  assign mispredict_q = mispredict_r;
  assign mispred_cnt  = cnt_r;

endmodule
